// File: rtl/multiword_adder_ctrl.sv
// Sequences a WORDS x 16-bit add/subtract through one shared 16-bit Adder,
// least-significant word first, chaining carry/borrow through Cin/Cout.
module multiword_adder_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Sub,
    input  logic [16*WORDS-1:0]   OpA,
    input  logic [16*WORDS-1:0]   OpB,
    output logic                  Busy,
    output logic                  Done,
    output logic [16*WORDS-1:0]   Result,
    output logic                  CarryOut,
    output logic                  OverflowOut,
    output logic                  Zero,
    output logic [15:0]           AdderA,
    output logic [15:0]           AdderB,
    output logic                  AdderCin,
    output logic [1:0]            AdderOp,
    input  logic [15:0]           AdderSum,
    input  logic                  AdderCout,
    input  logic                  AdderOverflow
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(WORDS - 1);

    localparam logic [1:0] OpIdle = 2'b00;
    localparam logic [1:0] OpAdd  = 2'b01;
    localparam logic [1:0] OpSub  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT                    stateReg;
    logic [IW-1:0]            idxReg;
    logic [IW-1:0]            idxNext;
    logic                     carryReg;
    logic [WORDS-1:0][15:0]   opAReg;
    logic [WORDS-1:0][15:0]   opBReg;
    logic [WORDS-1:0][15:0]   resultReg;

    assign idxNext  = idxReg + 1'b1;
    assign Result   = resultReg;
    assign Zero     = (resultReg == '0);
    // The carry register feeds the adder directly, so Cin is always a flop output.
    assign AdderCin = carryReg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stateReg    <= IDLE;
            idxReg      <= '0;
            carryReg    <= 1'b0;
            opAReg      <= '0;
            opBReg      <= '0;
            resultReg   <= '0;
            CarryOut    <= 1'b0;
            OverflowOut <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            AdderA      <= '0;
            AdderB      <= '0;
            AdderOp     <= OpIdle;
        end else begin
            case (stateReg)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        stateReg <= RUN;
                        opAReg   <= OpA;
                        opBReg   <= OpB;
                        idxReg   <= '0;
                        carryReg <= 1'b0;
                        Busy     <= 1'b1;
                        AdderA   <= OpA[15:0];
                        AdderB   <= OpB[15:0];
                        AdderOp  <= Sub ? OpSub : OpAdd;
                    end else begin
                        stateReg <= IDLE;
                        Busy     <= 1'b0;
                        AdderA   <= '0;
                        AdderB   <= '0;
                        AdderOp  <= OpIdle;
                        carryReg <= 1'b0;
                    end
                end

                RUN: begin
                    resultReg[idxReg] <= AdderSum;
                    if (idxReg == LastIdx) begin
                        stateReg    <= DONE;
                        CarryOut    <= AdderCout;
                        OverflowOut <= AdderOverflow;
                        Busy        <= 1'b0;
                        Done        <= 1'b1;
                        AdderA      <= '0;
                        AdderB      <= '0;
                        AdderOp     <= OpIdle;
                        carryReg    <= 1'b0;
                    end else begin
                        // Present the next word together with the carry just produced.
                        idxReg   <= idxNext;
                        carryReg <= AdderCout;
                        AdderA   <= opAReg[idxNext];
                        AdderB   <= opBReg[idxNext];
                    end
                end

                default: begin
                    stateReg <= IDLE;
                    Busy     <= 1'b0;
                    Done     <= 1'b0;
                    AdderOp  <= OpIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Bench for multiword_adder_ctrl: a behavioural 16-bit Adder closes the loop and
// every operation is checked against full-width arithmetic.
module tb_multiword_adder_ctrl;

    localparam int WORDS = 4;
    localparam int W = 16 * WORDS;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           Start;
    logic           Sub;
    logic [W-1:0]   OpA;
    logic [W-1:0]   OpB;
    logic           Busy;
    logic           Done;
    logic [W-1:0]   Result;
    logic           CarryOut;
    logic           OverflowOut;
    logic           Zero;
    logic [15:0]    AdderA;
    logic [15:0]    AdderB;
    logic           AdderCin;
    logic [1:0]     AdderOp;
    logic [15:0]    AdderSum;
    logic           AdderCout;
    logic           AdderOverflow;

    int totalCount = 0;
    int badCount   = 0;

    multiword_adder_ctrl #(.WORDS(WORDS)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Sub(Sub), .OpA(OpA), .OpB(OpB),
        .Busy(Busy), .Done(Done), .Result(Result), .CarryOut(CarryOut),
        .OverflowOut(OverflowOut), .Zero(Zero), .AdderA(AdderA), .AdderB(AdderB),
        .AdderCin(AdderCin), .AdderOp(AdderOp), .AdderSum(AdderSum),
        .AdderCout(AdderCout), .AdderOverflow(AdderOverflow)
    );

    always #5 Clk = ~Clk;

    // Shared 16-bit Adder: subtract treats Cin/Cout as borrow in/out.
    always_comb begin
        logic [16:0] t;
        t = '0;
        AdderSum = '0;
        AdderCout = 1'b0;
        AdderOverflow = 1'b0;
        if (AdderOp == 2'b01) begin
            t = {1'b0, AdderA} + {1'b0, AdderB} + {16'd0, AdderCin};
            AdderSum = t[15:0];
            AdderCout = t[16];
            AdderOverflow = (AdderA[15] == AdderB[15]) && (t[15] != AdderA[15]);
        end else if (AdderOp == 2'b11) begin
            t = {1'b0, AdderA} - {1'b0, AdderB} - {16'd0, AdderCin};
            AdderSum = t[15:0];
            AdderCout = t[16];
            AdderOverflow = (AdderA[15] != AdderB[15]) && (t[15] != AdderA[15]);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCount++;
        if (obs !== exp) begin
            badCount++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void refOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] r, output logic c, output logic v);
        logic [W:0] t;
        if (!s) begin
            t = {1'b0, a} + {1'b0, b};
            r = t[W-1:0];
            c = t[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r = a - b;
            c = (a < b);
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
    endfunction

    task automatic checkFinal(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic s);
        logic [W-1:0] r;
        logic c, v;
        refOp(a, b, s, r, c, v);
        check({tag, ".result"}, Result, r);
        check({tag, ".carry"}, CarryOut, c);
        check({tag, ".ovf"}, OverflowOut, v);
        check({tag, ".zero"}, Zero, (r == '0));
        $display("op %s a=%h b=%h sub=%0d result=%h carry=%0d ovf=%0d zero=%0d",
                 tag, a, b, s, Result, CarryOut, OverflowOut, Zero);
    endtask

    task automatic doOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
        int lat;
        int busyN;
        @(negedge Clk);
        Start = 1'b1; OpA = a; OpB = b; Sub = s;
        @(posedge Clk);
        #1 Start = 1'b0;
        lat = -1;
        busyN = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk);
            if (Done) begin
                lat = c - 1;
                break;
            end
            if (Busy) busyN++;
            check({tag, ".adderop"}, AdderOp, s ? 2'b11 : 2'b01);
            if (c == 1) check({tag, ".cin0"}, AdderCin, 1'b0);
        end
        check({tag, ".latency"}, lat, WORDS);
        check({tag, ".busycycles"}, busyN, WORDS);
        check({tag, ".busyAtDone"}, Busy, 1'b0);
        check({tag, ".opAtDone"}, AdderOp, 2'b00);
        checkFinal(tag, a, b, s);
        @(negedge Clk);
        check({tag, ".donePulse"}, Done, 1'b0);
    endtask

    initial begin
        logic [W-1:0] a, b, a2, b2;
        logic s;
        int firstDone, secondDone, doneCount;

        Reset = 1'b1; Start = 1'b0; Sub = 1'b0; OpA = '0; OpB = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst.result", Result, '0);
        check("rst.zero", Zero, 1'b1);
        check("rst.busy", Busy, 1'b0);
        check("rst.done", Done, 1'b0);
        check("rst.op", AdderOp, 2'b00);
        check("rst.carry", CarryOut, 1'b0);
        Reset = 1'b0;

        doOp("ripple", 64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        check("ripple.literal", Result, 64'h0001_0000_0000_0000);
        doOp("borrow", 64'h0, 64'h1, 1'b1);
        check("borrow.literal", Result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("borrow.carrylit", CarryOut, 1'b1);
        doOp("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        check("sovf.literal", Result, 64'h8000_0000_0000_0000);
        check("sovf.ovflit", OverflowOut, 1'b1);
        doOp("equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1);
        check("equal.zerolit", Zero, 1'b1);

        // Second Start during RUN is ignored; holding it through DONE launches the next op.
        a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_2222_3333_4444;
        a2 = 64'h8000_0000_0000_0000; b2 = 64'h0000_0000_0000_0001;
        @(negedge Clk);
        Start = 1'b1; OpA = a; OpB = b; Sub = 1'b0;
        @(posedge Clk);
        #1 Start = 1'b0;
        firstDone = -1; secondDone = -1; doneCount = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clk);
            if (c == 2) begin
                Start = 1'b1; OpA = a2; OpB = b2; Sub = 1'b1;
            end
            if (Done) begin
                doneCount++;
                if (firstDone < 0) begin
                    firstDone = c;
                    checkFinal("overlap1", a, b, 1'b0);
                end else begin
                    secondDone = c;
                    checkFinal("overlap2", a2, b2, 1'b1);
                end
            end
            if (c == 6) begin
                check("overlap.relaunchBusy", Busy, 1'b1);
                Start = 1'b0;
            end
        end
        check("overlap.firstDone", firstDone, WORDS + 1);
        check("overlap.secondDone", secondDone, 2 * WORDS + 2);
        check("overlap.doneCount", doneCount, 2);

        // Asynchronous reset in the second RUN cycle discards the operation.
        @(negedge Clk);
        Start = 1'b1; OpA = 64'hFFFF_0000_FFFF_0000; OpB = 64'h0F0F_0F0F_0F0F_0F0F; Sub = 1'b0;
        @(posedge Clk);
        #1 Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("midrst.result", Result, '0);
        check("midrst.zero", Zero, 1'b1);
        check("midrst.busy", Busy, 1'b0);
        check("midrst.op", AdderOp, 2'b00);
        check("midrst.ovf", OverflowOut, 1'b0);
        check("midrst.carry", CarryOut, 1'b0);
        @(negedge Clk);
        Reset = 1'b0;
        doneCount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (Done) doneCount++;
        end
        check("midrst.noDone", doneCount, 0);
        doOp("afterRst", 64'hFFFF_FFFF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b0);

        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case (i % 5)
                0: b = ~a;
                1: b = a;
                2: a[47:0] = 48'hFFFF_FFFF_FFFF;
                default: ;
            endcase
            s = 1'($urandom_range(0, 1));
            doOp($sformatf("rand%0d", i), a, b, s);
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
